// File: rtl/riscv_dift_tag_check.sv
// DIFT security-policy stage: checks operand/address/PC/instruction tags against the TCR,
// holds a security-exception request until acknowledged, and serves per-class propagation modes.
module riscv_dift_tag_check #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_we_i,
  input  logic                 cfg_sel_i,
  input  logic [31:0]          cfg_wdata_i,
  output logic [31:0]          tcr_o,
  output logic [31:0]          tpr_o,
  input  logic                 chk_valid_i,
  output logic                 chk_ready_o,
  input  logic [2:0]           chk_class_i,
  input  logic                 tag_s1_i,
  input  logic                 tag_s2_i,
  input  logic                 tag_d_i,
  input  logic                 tag_sa_i,
  input  logic                 tag_da_i,
  input  logic                 tag_pc_i,
  input  logic                 tag_instr_i,
  input  logic [31:0]          pc_i,
  output logic [1:0]           prop_mode_o,
  output logic                 exc_req_o,
  input  logic                 exc_ack_i,
  output logic [22:0]          exc_cause_o,
  output logic [31:0]          exc_pc_o,
  input  logic                 viol_clr_i,
  output logic [CNT_WIDTH-1:0] viol_cnt_o
);
  localparam int NCHK = 23;
  localparam int NPRP = 14;

  typedef enum logic {IDLE, REPORT} state_e;
  typedef enum logic [2:0] {
    C_INT, C_BRANCH, C_JUMP, C_SHIFT, C_CMP, C_LOGICAL, C_LDST, C_NONE
  } cls_e;
  typedef struct packed {
    logic [NCHK-1:0] cause;
    logic [31:0]     pc;
  } exc_rec_t;

  state_e               state_q, state_d;
  logic [NCHK-1:0]      tcr_q;
  logic [NPRP-1:0]      tpr_q;
  exc_rec_t             rec_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [NCHK-1:0]      v;
  logic [7:0][1:0]      mode_tab;
  logic                 fire, hit;
  logic                 unused_wdata;

  assign unused_wdata = ^cfg_wdata_i[31:NCHK];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcr_q <= '0;
      tpr_q <= '0;
    end else if (cfg_we_i) begin
      if (cfg_sel_i) tpr_q <= cfg_wdata_i[NPRP-1:0];
      else           tcr_q <= cfg_wdata_i[NCHK-1:0];
    end
  end

  assign tcr_o = {{(32-NCHK){1'b0}}, tcr_q};
  assign tpr_o = {{(32-NPRP){1'b0}}, tpr_q};

  // Class 7 (NONE) falls on the zero-padded top entry.
  assign mode_tab    = {2'b00, tpr_q};
  assign prop_mode_o = mode_tab[chk_class_i];

  assign chk_ready_o = (state_q == IDLE);
  assign exc_req_o   = (state_q == REPORT);
  assign fire        = chk_valid_i & chk_ready_o;

  always_comb begin
    v = '0;
    if (fire) begin
      case (cls_e'(chk_class_i))
        C_INT:     v[2:0]   = {tag_d_i, tag_s2_i, tag_s1_i};
        C_BRANCH:  v[4:3]   = {tag_s2_i, tag_s1_i};
        C_JUMP:    v[7:5]   = {tag_d_i, tag_s2_i, tag_s1_i};
        C_SHIFT:   v[10:8]  = {tag_d_i, tag_s2_i, tag_s1_i};
        C_CMP:     v[13:11] = {tag_d_i, tag_s2_i, tag_s1_i};
        C_LOGICAL: v[16:14] = {tag_d_i, tag_s2_i, tag_s1_i};
        C_LDST:    v[20:17] = {tag_da_i, tag_d_i, tag_sa_i, tag_s1_i};
        default:   ;
      endcase
      v[21] = tag_pc_i;
      v[22] = tag_instr_i;
      v     = v & tcr_q;
    end
  end

  assign hit = |v;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hit)       state_d = REPORT;
      REPORT:  if (exc_ack_i) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rec_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (hit) rec_q <= '{cause: v, pc: pc_i};
      // Clear takes priority over a same-cycle increment.
      if (viol_clr_i)               cnt_q <= '0;
      else if (hit && cnt_q != '1)  cnt_q <= cnt_q + 1'b1;
    end
  end

  assign exc_cause_o = rec_q.cause;
  assign exc_pc_o    = rec_q.pc;
  assign viol_cnt_o  = cnt_q;

endmodule
